// File: rtl/mips_mc_pkg.sv
// Definitions shared by the multicycle control FSM, the datapath and the memory interface.
package mips_mc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic IORD_PC  = 1'b0;
  localparam logic IORD_ALU = 1'b1;

  localparam int TIMER_W = 8;

  // What to do with the returned word once the access finishes.
  typedef struct packed {
    logic iord;
    logic irwrite;
    logic we;
  } access_kind_t;

endpackage

// File: rtl/mc_access_timer.sv
// Loadable up-counter with clear, enable and a terminal-count flag against a limit.
module mc_access_timer
  import mips_mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               tc
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/mc_mem_interface.sv
// Memory-side stage of the multicycle core: req/ack access to unified memory, owns IR and MDR,
// and stalls the control FSM until the access completes or times out.
module mc_mem_interface
  import mips_mc_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      TIMEOUT  = 255,
  parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_INSTR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] mdr,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             bus_err,
  output logic             align_err
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

  mem_state_e   state;
  access_kind_t kind;

  logic [WIDTH-1:0] addr_sel;
  logic             start;
  logic             bad_request;
  logic             accept;
  logic             reject;
  logic             busy;
  logic             tc;

  assign addr_sel    = (IorD == IORD_ALU) ? alu_out : pc;
  assign start       = MemRead | MemWrite;
  assign bad_request = (addr_sel[1:0] != 2'b00) | (MemRead & MemWrite);
  assign busy        = (state == BUSY);
  assign accept      = (state == IDLE) & start & ~bad_request;
  assign reject      = (state == IDLE) & start & bad_request;

  // Gated by reset so the FSM is released immediately even if control inputs are still high.
  assign stall = reset & (accept | (busy & ~mem_ack & ~tc));

  mc_access_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .load       (1'b0),
    .load_value ('0),
    .enable     (busy),
    .limit      (LIMIT),
    .tc         (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      kind      <= '0;
      instr     <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= addr_sel;
            mem_wdata <= wdata;
            kind      <= '{iord: IorD, irwrite: IRWrite, we: MemWrite};
          end else if (reject) begin
            align_err <= 1'b1;
          end
        end
        BUSY: begin
          // An ack on the terminal-count cycle still completes normally.
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!kind.we) begin
              if (kind.iord == IORD_ALU) begin
                mdr <= mem_rdata;
              end else if (kind.irwrite) begin
                instr <= mem_rdata;
              end
            end
          end else if (tc) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= 1'b1;
            if (!kind.we) begin
              if (kind.iord == IORD_ALU) begin
                mdr <= '0;
              end else if (kind.irwrite) begin
                instr <= NOP_WORD;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_mem_interface.sv
// Randomized scoreboard bench for mc_mem_interface against a word-level memory reference model.
module tb_mc_mem_interface;
  import mips_mc_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead, MemWrite, IorD, IRWrite;
  logic [31:0] pc, alu_out, wdata;
  logic [31:0] instr, mdr, mem_addr, mem_wdata, mem_rdata;
  logic        stall, mem_req, mem_we, mem_ack, bus_err, align_err;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          stall_cycles;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        bus_err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int compared   = 0;
  int mismatched = 0;
  int ack_after  = 0;
  int busy_cnt   = 0;
  int stall_cnt  = 0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] model_instr = '0;
  logic [31:0] model_mdr   = '0;
  logic        model_bus_err   = 1'b0;
  logic        model_align_err = 1'b0;

  mc_mem_interface #(.WIDTH(32), .TIMEOUT(TO), .NOP_WORD(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .pc        (pc),
    .alu_out   (alu_out),
    .wdata     (wdata),
    .instr     (instr),
    .mdr       (mdr),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Memory: acks the Nth BUSY cycle (never when ack_after is 0) and sprinkles idle acks.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        busy_cnt = 0;
        mem_ack  = 1'b0;
      end else begin
        busy_cnt = mem_req ? busy_cnt + 1 : 0;
        mem_ack  = mem_req ? (busy_cnt == ack_after) : ($urandom_range(0, 3) == 0);
        if (mem_ack && mem_req) begin
          if (mem_we) bus_mem[mem_addr] = mem_wdata;
          mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : init_word(mem_addr);
        end else begin
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: every cycle where the FSM is released out of BUSY retires one expected access.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_cnt = 0;
      end else begin
        if (stall) stall_cnt++;
        if (mem_req && !stall) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_completion: got access at %h, expected none", mem_addr);
          end else begin
            mon_e = sb.pop_front();
            checkOutput("mem_addr", mem_addr, mon_e.addr);
            checkOutput("mem_we", 32'(mem_we), 32'(mon_e.we));
            checkOutput("mem_wdata", mem_wdata, mon_e.wdata);
            checkOutput("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall_cycles));
            @(posedge clk);
            #1;
            checkOutput("instr", instr, mon_e.instr);
            checkOutput("mdr", mdr, mon_e.mdr);
            checkOutput("bus_err", 32'(bus_err), 32'(mon_e.bus_err));
            checkOutput("mem_req_drop", 32'(mem_req), 32'(0));
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // Issues one access starting at posedge+1; ack = BUSY cycle of the ack, 0 = never.
  task automatic applyStimulus(input logic rd, input logic wr, input logic iord, input logic irw,
                               input logic [31:0] addr, input logic [31:0] wd, input int ack);
    exp_t e;
    bit   timed;
    bit   done;
    IorD    = iord;
    pc      = iord ? $urandom : addr;
    alu_out = iord ? addr : $urandom;
    wdata   = wd;
    IRWrite = irw;
    if (addr[1:0] != 2'b00 || (rd && wr)) begin
      model_align_err = 1'b1;
      MemRead  = rd;
      MemWrite = wr;
      @(negedge clk);
      checkOutput("reject_stall", 32'(stall), 32'(0));
      checkOutput("reject_req", 32'(mem_req), 32'(0));
      @(posedge clk);
      #1;
      checkOutput("align_err", 32'(align_err), 32'(model_align_err));
      checkOutput("reject_req_after", 32'(mem_req), 32'(0));
      checkOutput("reject_instr", instr, model_instr);
      checkOutput("reject_mdr", mdr, model_mdr);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      return;
    end
    timed = (ack == 0) || (ack > TO + 1);
    if (!timed) begin
      if (wr) ref_mem[addr] = wd;
      else if (iord) model_mdr = ref_read(addr);
      else if (irw) model_instr = ref_read(addr);
    end else begin
      model_bus_err = 1'b1;
      if (!wr) begin
        if (iord) model_mdr = 32'h0;
        else if (irw) model_instr = NOP_INSTR;
      end
    end
    e.addr         = addr;
    e.we           = wr;
    e.wdata        = wd;
    e.stall_cycles = timed ? TO + 1 : ack;
    e.instr        = model_instr;
    e.mdr          = model_mdr;
    e.bus_err      = model_bus_err;
    sb.push_back(e);
    ack_after = ack;
    MemRead   = rd;
    MemWrite  = wr;
    done = 0;
    for (int i = 0; i < TO + 8 && !done; i++) begin
      @(negedge clk);
      if (mem_req && !stall) done = 1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL completion_wait: got no completion for %h, expected one within %0d cycles", addr, TO + 8);
    end
    @(posedge clk);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected $finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int op;
    logic [31:0] a;
    MemRead = 1'b1; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b1;
    pc = 32'h0; alu_out = 32'h0; wdata = 32'h0;
    #1;
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_mdr", mdr, 32'h0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'(0));
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_flags", {30'h0, bus_err, align_err}, 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'(0));
    MemRead = 1'b0; IRWrite = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    ref_mem[32'h40]  = 32'h8C43_0004; bus_mem[32'h40]  = 32'h8C43_0004;
    ref_mem[32'h100] = 32'hDEAD_BEEF; bus_mem[32'h100] = 32'hDEAD_BEEF;

    $display("[TB] directed accesses");
    applyStimulus(1, 0, IORD_PC,  1, 32'h40,  $urandom, 3);
    applyStimulus(1, 0, IORD_ALU, 0, 32'h100, $urandom, 1);
    applyStimulus(0, 1, IORD_ALU, 0, 32'h200, 32'h1234_5678, 2);
    applyStimulus(1, 0, IORD_ALU, 0, 32'h200, $urandom, 1);
    applyStimulus(1, 0, IORD_PC,  1, 32'h44,  $urandom, TO + 1);

    $display("[TB] random accesses");
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      a  = 32'h300 + 32'(4 * $urandom_range(0, 7));
      case (op)
        0:       applyStimulus(1, 0, IORD_PC,  1, a, $urandom, $urandom_range(1, TO + 1));
        1:       applyStimulus(1, 0, IORD_PC,  0, a, $urandom, $urandom_range(1, TO + 1));
        2:       applyStimulus(1, 0, IORD_ALU, 0, a, $urandom, $urandom_range(1, TO + 1));
        default: applyStimulus(0, 1, IORD_ALU, 0, a, $urandom, $urandom_range(1, TO + 1));
      endcase
    end

    $display("[TB] rejected requests");
    applyStimulus(1, 0, IORD_ALU, 0, 32'h102, $urandom, 1);
    applyStimulus(1, 1, IORD_ALU, 0, 32'h104, $urandom, 1);

    $display("[TB] timeouts");
    applyStimulus(1, 0, IORD_PC,  1, 32'h48,  $urandom, 0);
    applyStimulus(1, 0, IORD_ALU, 0, 32'h100, $urandom, 1);
    applyStimulus(1, 0, IORD_ALU, 0, 32'h104, $urandom, 0);

    $display("[TB] reset during access");
    ack_after = 0;
    IorD = IORD_PC; pc = 32'h80; IRWrite = 1'b1; MemRead = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    checkOutput("async_mem_req", 32'(mem_req), 32'(0));
    checkOutput("async_stall", 32'(stall), 32'(0));
    checkOutput("async_flags", {30'h0, bus_err, align_err}, 32'h0);
    checkOutput("async_instr", instr, 32'h0);
    MemRead = 1'b0; IRWrite = 1'b0;
    model_instr = '0; model_mdr = '0; model_bus_err = 1'b0; model_align_err = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, IORD_PC, 1, 32'h40, $urandom, 2);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mc_mem_interface.md
Name: mc_mem_interface

Overview:
- Memory-side stage directly downstream of the multicycle control unit in the multicycle core.
- Consumes MemRead/MemWrite/IorD/IRWrite, selects the PC or the ALUOut address, and runs a req/ack handshake to a unified instruction/data memory with variable latency.
- Owns the Instruction Register and the Memory Data Register.
- Drives a stall back to the control FSM so the FSM holds its state until the access completes.

Parameters:
- WIDTH, 32, data and address width.
- TIMEOUT, 255, maximum BUSY cycles before the access is aborted; must be ≥1 and fit in 8 bits.
- NOP_WORD, 32'h0000_0000, value loaded into IR on an aborted fetch.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  control: read request.
- MemWrite  in  1  control: write request.
- IorD  in  1  0 = instruction fetch (address PC), 1 = data access (address ALUOut).
- IRWrite  in  1  control: load IR on fetch completion.
- pc  in  WIDTH  program counter.
- alu_out  in  WIDTH  data address.
- wdata  in  WIDTH  store data (register B).
- instr  out  WIDTH  IR contents.
- mdr  out  WIDTH  MDR contents.
- stall  out  1  freeze the control FSM and the PC.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  WIDTH  registered access address.
- mem_wdata  out  WIDTH  registered store data.
- mem_rdata  in  WIDTH  read data, valid while mem_ack=1.
- mem_ack  in  1  one-cycle completion strobe.
- bus_err  out  1  sticky: a timeout occurred.
- align_err  out  1  sticky: misaligned address or MemRead and MemWrite asserted together.

Behaviour:
- Reset (reset=0, asynchronous) forces all of the following, including mid-access:
  - state = IDLE.
  - instr = 0, mdr = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - bus_err = 0, align_err = 0, timeout counter = 0.
  - stall = 0.
- Define start = MemRead | MemWrite, and addr_sel = IorD ? alu_out : pc.
- IDLE, start=1, addr_sel[1:0]=00, MemRead&MemWrite=0:
  - Latch mem_addr = addr_sel, mem_we = MemWrite, mem_wdata = wdata.
  - Latch kind = {IorD, IRWrite}.
  - Clear the counter, go to BUSY.
  - stall = 1 combinationally in this cycle.
- IDLE, start=1 but misaligned, or both MemRead and MemWrite asserted:
  - Set align_err, no memory access, stall = 0.
  - IR and MDR unchanged.
- BUSY:
  - mem_req = 1; mem_addr, mem_we and mem_wdata held stable.
  - Counter increments each cycle.
  - stall = ~mem_ack: a combinational path from mem_ack to stall is intended.
  - The FSM advances on the same edge that the data is captured.
- BUSY, mem_ack=1, return to IDLE on the next edge:
  - Read with latched IorD=0 and IRWrite=1: instr <= mem_rdata.
  - Read with latched IorD=1: mdr <= mem_rdata.
  - Write: nothing captured.
  - mem_req falls on the next edge.
- BUSY, counter == TIMEOUT with mem_ack=0:
  - Set bus_err; stall = 0 this cycle.
  - A fetch loads instr <= NOP_WORD; a data read loads mdr <= 0.
  - Return to IDLE; mem_req drops.
- mem_ack=1 while in IDLE: ignored.
- mem_ack on the same cycle the counter hits TIMEOUT: ack wins; no bus_err.
- Control inputs are ignored while in BUSY (the FSM is stalled, so they are stable).
- Latency from start to FSM advance is 1 + N cycles, where N = cycles until ack. A zero-wait memory (ack in the first BUSY cycle) gives 2 cycles.
- The sticky error flags clear only on reset.
- Back-to-back accesses: after return to IDLE, a new start is accepted on the very next cycle.

Decomposition:
- Shared package mips_mc_pkg holds:
  - state encoding (IDLE = 1'b0, BUSY = 1'b1).
  - NOP constant.
  - IorD select constants (IORD_PC = 0, IORD_ALU = 1), also used by the control FSM and the datapath.
- Sub-module mc_access_timer: loadable 8-bit counter with clear, enable and terminal-count output. Used for the timeout.

Test Plan:
- Fetch, ack after 3 BUSY cycles:
  - Stimulus: MemRead=1, IorD=0, IRWrite=1, pc=0x0000_0040, mem_rdata=0x8C43_0004.
  - Expect mem_addr=0x40 and mem_req=1 for 3 cycles.
  - Expect stall=1 for 3 cycles, then 0 in the ack cycle.
  - Expect instr=0x8C43_0004 after the ack edge.
- Load word with zero wait:
  - Stimulus: MemRead=1, IorD=1, alu_out=0x100, ack in the first BUSY cycle, rdata=0xDEAD_BEEF.
  - Expect mdr=0xDEAD_BEEF and instr unchanged.
  - Expect total stall of 1 cycle.
- Store:
  - Stimulus: MemWrite=1, IorD=1, alu_out=0x200, wdata=0x1234_5678.
  - Expect mem_we=1, mem_wdata=0x1234_5678, mem_addr=0x200.
  - Expect IR and MDR unchanged.
- Timeout with TIMEOUT=4 and no ack on a fetch:
  - Expect bus_err=1, instr=0x0000_0000.
  - Expect stall to drop after 4 BUSY cycles, then IDLE.
- Misaligned address and conflicting request:
  - Stimulus: alu_out=0x102 with MemRead=1, IorD=1.
  - Expect align_err=1, mem_req never asserted, stall=0.
  - Repeat with MemRead=MemWrite=1: same response.
- Reset mid-BUSY:
  - Stimulus: assert reset=0 two cycles into an access.
  - Expect mem_req, stall and the flags at 0 immediately, without waiting for a clock edge.
  - After release, a new fetch completes normally.
